// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak sponge types, constants and per-mode helpers
// Shared by keccak_sponge_ctrl and keccak_pad_gen: mode and sponge-state
// enums, lane/round sizing, rate/digest lane counts and domain suffixes.
package keccak_pkg;

   localparam int LANE_SIZE        = 64;
   localparam int MAX_ROUNDS       = 24;
   localparam int ROUND_INDEX_SIZE = 5;
   localparam int LANE_INDEX_SIZE  = 5;

   typedef enum logic [2:0] {
      MODE_SHA3_256 = 3'd0,
      MODE_SHA3_512 = 3'd1,
      MODE_SHAKE128 = 3'd2,
      MODE_SHAKE256 = 3'd3
   } keccak_mode;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ABSORB  = 3'd1,
      ST_PAD     = 3'd2,
      ST_PERMUTE = 3'd3,
      ST_SQUEEZE = 3'd4
   } sponge_state_e;

   localparam logic [4:0] RATE_LANES_SHA3_256   = 5'd17;
   localparam logic [4:0] RATE_LANES_SHA3_512   = 5'd9;
   localparam logic [4:0] RATE_LANES_SHAKE128   = 5'd21;
   localparam logic [4:0] RATE_LANES_SHAKE256   = 5'd17;
   localparam logic [4:0] DIGEST_LANES_SHA3_256 = 5'd4;
   localparam logic [4:0] DIGEST_LANES_SHA3_512 = 5'd8;
   localparam logic [7:0] SUFFIX_SHA3           = 8'h06;
   localparam logic [7:0] SUFFIX_SHAKE          = 8'h1F;

   function automatic logic is_shake(input keccak_mode m);
      return (m == MODE_SHAKE128) || (m == MODE_SHAKE256);
   endfunction

   function automatic logic is_sha3(input keccak_mode m);
      return (m == MODE_SHA3_256) || (m == MODE_SHA3_512);
   endfunction

   function automatic logic [4:0] rate_lanes(input keccak_mode m);
      case (m)
         MODE_SHA3_512: return RATE_LANES_SHA3_512;
         MODE_SHAKE128: return RATE_LANES_SHAKE128;
         MODE_SHAKE256: return RATE_LANES_SHAKE256;
         default:       return RATE_LANES_SHA3_256;
      endcase
   endfunction

   // SHAKE has no fixed digest; its squeeze length is bounded by rate and stop.
   function automatic logic [4:0] digest_lanes(input keccak_mode m);
      case (m)
         MODE_SHA3_512: return DIGEST_LANES_SHA3_512;
         default:       return DIGEST_LANES_SHA3_256;
      endcase
   endfunction

   function automatic logic [7:0] domain_suffix(input keccak_mode m);
      return is_shake(m) ? SUFFIX_SHAKE : SUFFIX_SHA3;
   endfunction

endpackage

// File: rtl/keccak_pad_gen.sv
// rtl/keccak_pad_gen.sv - last-beat byte masking, suffix and end-bit insertion
// Ports:
//   lane_i      : raw lane, byte 0 in bits [7:0]
//   n_bytes_i   : bytes of lane_i kept (>= bytes-per-lane keeps all, no suffix)
//   suffix_i    : domain suffix placed in byte n_bytes_i
//   last_lane_i : OR 0x80 into the top byte (final lane of the rate)
//   lane_o      : padded lane
module keccak_pad_gen
   import keccak_pkg::*;
#(
   parameter int LANE_W = LANE_SIZE
)
(
   input  logic [LANE_W-1:0] lane_i,
   input  logic [3:0]        n_bytes_i,
   input  logic [7:0]        suffix_i,
   input  logic              last_lane_i,
   output logic [LANE_W-1:0] lane_o
);

   localparam int NB = LANE_W / 8;

   always_comb begin
      lane_o = '0;
      for (int b = 0; b < NB; b++) begin
         if (b < int'(n_bytes_i)) begin
            lane_o[8*b +: 8] = lane_i[8*b +: 8];
         end else if (b == int'(n_bytes_i)) begin
            lane_o[8*b +: 8] = suffix_i;
         end
      end
      // Applied after the suffix so a suffix landing in the top byte merges.
      if (last_lane_i) begin
         lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8] | 8'h80;
      end
   end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - Keccak-f[1600] sponge sequencer (absorb/pad/permute/squeeze)
// Optional feature macro: KECCAK_SHAKE_EN (SHAKE128/256 with stop_i and re-permute).
// Ports:
//   start_i/mode_i/stop_i          : message start, mode select, SHAKE stop
//   in_valid_i/in_ready_o/in_data_i/in_last_i/in_bytes_i : message lane stream
//   clear_o/absorb_we_o/lane_idx_o/absorb_data_o          : state array writes
//   round_en_o/round_idx_o         : round datapath step and iota index
//   st_lane_i                      : state lane at lane_idx_o
//   out_valid_o/out_ready_i/out_data_o : digest/XOF lane stream
//   busy_o/done_o/err_o            : status
module keccak_sponge_ctrl
   import keccak_pkg::*;
#(
   parameter int LANE_W = LANE_SIZE,
   parameter int ROUNDS = MAX_ROUNDS
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  keccak_mode                  mode_i,
   input  logic                        stop_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [LANE_W-1:0]           in_data_i,
   input  logic                        in_last_i,
   input  logic [3:0]                  in_bytes_i,
   output logic                        clear_o,
   output logic                        absorb_we_o,
   output logic [4:0]                  lane_idx_o,
   output logic [LANE_W-1:0]           absorb_data_o,
   output logic                        round_en_o,
   output logic [ROUND_INDEX_SIZE-1:0] round_idx_o,
   input  logic [LANE_W-1:0]           st_lane_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [LANE_W-1:0]           out_data_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);

   sponge_state_e               state_q, state_d;
   sponge_state_e               ret_q, ret_d;
   keccak_mode                  mode_q, mode_d;
   logic [4:0]                  cnt_q, cnt_d;
   logic [ROUND_INDEX_SIZE-1:0] rnd_q, rnd_d;
   logic                        pend_q, pend_d;

   logic [4:0]                  rate_m1;
   logic [4:0]                  dig_m1;
   logic [7:0]                  sfx;
   logic                        start_ok;
   logic                        at_rate_end;
   logic                        short_last;

   logic [LANE_W-1:0]           pad_lane;
   logic [3:0]                  pad_n;
   logic [7:0]                  pad_sfx;
   logic                        pad_last;
   logic [LANE_W-1:0]           pad_word;

   assign rate_m1     = rate_lanes(mode_q) - 5'd1;
   assign dig_m1      = digest_lanes(mode_q) - 5'd1;
   assign sfx         = domain_suffix(mode_q);
   assign at_rate_end = (cnt_q == rate_m1);
   assign short_last  = in_last_i && (in_bytes_i < 4'd8);

`ifdef KECCAK_SHAKE_EN
   assign start_ok = is_sha3(mode_i) || is_shake(mode_i);
`else
   assign start_ok = is_sha3(mode_i);
   logic unused_stop;
   assign unused_stop = stop_i;
`endif

   keccak_pad_gen #(.LANE_W(LANE_W)) u_pad_gen (
      .lane_i      (pad_lane),
      .n_bytes_i   (pad_n),
      .suffix_i    (pad_sfx),
      .last_lane_i (pad_last),
      .lane_o      (pad_word)
   );

   assign busy_o      = (state_q != ST_IDLE);
   assign lane_idx_o  = cnt_q;
   assign round_idx_o = rnd_q;

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      mode_d        = mode_q;
      cnt_d         = cnt_q;
      rnd_d         = rnd_q;
      pend_d        = pend_q;
      clear_o       = 1'b0;
      err_o         = 1'b0;
      done_o        = 1'b0;
      in_ready_o    = 1'b0;
      absorb_we_o   = 1'b0;
      absorb_data_o = '0;
      round_en_o    = 1'b0;
      out_valid_o   = 1'b0;
      out_data_o    = '0;
      pad_lane      = '0;
      pad_n         = 4'd8;
      pad_sfx       = sfx;
      pad_last      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (start_ok) begin
                  clear_o = 1'b1;
                  mode_d  = mode_i;
                  cnt_d   = 5'd0;
                  rnd_d   = '0;
                  pend_d  = 1'b0;
                  state_d = ST_ABSORB;
               end else begin
                  err_o = 1'b1;
               end
            end
         end

         ST_ABSORB: begin
            in_ready_o = 1'b1;
            pad_lane   = in_data_i;
            pad_n      = short_last ? in_bytes_i : 4'd8;
            pad_last   = short_last && at_rate_end;
            if (in_valid_i) begin
               absorb_we_o   = 1'b1;
               absorb_data_o = pad_word;
               if (!in_last_i) begin
                  if (at_rate_end) begin
                     state_d = ST_PERMUTE;
                     ret_d   = ST_ABSORB;
                     cnt_d   = 5'd0;
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end else if (short_last) begin
                  if (at_rate_end) begin
                     state_d = ST_PERMUTE;
                     ret_d   = ST_SQUEEZE;
                     cnt_d   = 5'd0;
                  end else begin
                     // Suffix already written; PAD only needs the end bit.
                     state_d = ST_PAD;
                     cnt_d   = rate_m1;
                  end
               end else begin
                  // Full final lane: the suffix goes into the next lane slot,
                  // which may be lane 0 of a fresh block after a permute.
                  pend_d = 1'b1;
                  if (at_rate_end) begin
                     state_d = ST_PERMUTE;
                     ret_d   = ST_PAD;
                     cnt_d   = 5'd0;
                  end else begin
                     state_d = ST_PAD;
                     cnt_d   = cnt_q + 5'd1;
                  end
               end
            end
         end

         ST_PAD: begin
            absorb_we_o   = 1'b1;
            pad_n         = 4'd0;
            pad_sfx       = pend_q ? sfx : 8'h00;
            pad_last      = at_rate_end;
            absorb_data_o = pad_word;
            pend_d        = 1'b0;
            if (at_rate_end) begin
               state_d = ST_PERMUTE;
               ret_d   = ST_SQUEEZE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = rate_m1;
            end
         end

         ST_PERMUTE: begin
            round_en_o = 1'b1;
            if (rnd_q == ROUND_INDEX_SIZE'(ROUNDS - 1)) begin
               rnd_d   = '0;
               cnt_d   = 5'd0;
               state_d = ret_q;
            end else begin
               rnd_d = rnd_q + 1'b1;
            end
         end

         ST_SQUEEZE: begin
            out_valid_o = 1'b1;
            out_data_o  = st_lane_i;
`ifdef KECCAK_SHAKE_EN
            if (is_shake(mode_q)) begin
               if (stop_i) begin
                  done_o  = 1'b1;
                  cnt_d   = 5'd0;
                  state_d = ST_IDLE;
               end else if (out_ready_i) begin
                  if (at_rate_end) begin
                     state_d = ST_PERMUTE;
                     ret_d   = ST_SQUEEZE;
                     cnt_d   = 5'd0;
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end
            end else
`endif
            if (out_ready_i) begin
               if (cnt_q == dig_m1) begin
                  done_o  = 1'b1;
                  cnt_d   = 5'd0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            rnd_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         mode_q  <= MODE_SHA3_256;
         cnt_q   <= 5'd0;
         rnd_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         pend_q  <= pend_d;
      end
   end

endmodule
